csi_pkt_sequencer: RTL and testbench

// Sequences the CSI-2 packet handler datapath: takes decoded packet headers and merged 16-bit lane

---
 rtl/csi_pkt_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_csi_pkt_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/csi_pkt_sequencer.sv
// CSI-2 packet sequencer: header decode, VC filter, frame/line tracking, payload beat counting
// and CRC word extraction between the lane merger/ECC stage and the pixel unpacker.
module csi_pkt_sequencer #(
  parameter logic [1:0]  VC     = 2'd0,
  parameter int unsigned MAX_WC = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [23:0] hdr_in_i,
  input  logic        hdr_valid_i,
  input  logic        ecc_error_i,
  input  logic [15:0] data_in_i,
  input  logic        data_valid_i,
  input  logic        eot_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic [5:0]  pix_dt_o,
  output logic        frame_active_o,
  output logic        line_active_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] frame_num_o,
  output logic [15:0] crc_word_o,
  output logic        crc_valid_o,
  output logic        pkt_done_o,
  output logic        err_ecc_o,
  output logic        err_wc_o,
  output logic        err_trunc_o
);

  typedef enum logic [2:0] {StIdle, StPayload, StCrc, StSkip, StResync} state_e;

  localparam logic [5:0] DtFs = 6'h00;
  localparam logic [5:0] DtFe = 6'h01;
  localparam logic [5:0] DtLs = 6'h02;
  localparam logic [5:0] DtLe = 6'h03;

  state_e      state_q, state_d;
  logic [15:0] beats_q, beats_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic [5:0]  pix_dt_q, pix_dt_d;
  logic        frame_active_q, frame_active_d;
  logic        line_active_q, line_active_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic [15:0] crc_word_q, crc_word_d;
  logic        crc_valid_q, crc_valid_d;
  logic        pkt_done_q, pkt_done_d;
  logic        err_ecc_q, err_ecc_d;
  logic        err_wc_q, err_wc_d;
  logic        err_trunc_q, err_trunc_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        hdr_long;
  logic        wc_bad;
  logic [16:0] skip_sum;
  logic [15:0] skip_beats;

  assign hdr_dt     = hdr_in_i[5:0];
  assign hdr_vc     = hdr_in_i[7:6];
  assign hdr_wc     = hdr_in_i[23:8];
  assign hdr_long   = (hdr_dt >= 6'h10);
  assign wc_bad     = hdr_wc[0] || ({16'd0, hdr_wc} > MAX_WC);
  // Skipped packets consume payload plus the CRC word, rounded up to whole beats.
  assign skip_sum   = {1'b0, hdr_wc} + 17'd3;
  assign skip_beats = skip_sum[16:1];

  always_comb begin
    state_d        = state_q;
    beats_d        = beats_q;
    pix_data_d     = pix_data_q;
    pix_valid_d    = 1'b0;
    pix_dt_d       = pix_dt_q;
    frame_active_d = frame_active_q;
    line_active_d  = line_active_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    frame_num_d    = frame_num_q;
    crc_word_d     = crc_word_q;
    crc_valid_d    = 1'b0;
    pkt_done_d     = 1'b0;
    err_ecc_d      = 1'b0;
    err_wc_d       = 1'b0;
    err_trunc_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A header arriving with eot is discarded along with the transmission.
        if (hdr_valid_i && !eot_i) begin
          if (ecc_error_i) begin
            err_ecc_d = 1'b1;
            state_d   = StResync;
          end else if (hdr_vc != VC) begin
            if (hdr_long) begin
              beats_d = skip_beats;
              state_d = StSkip;
            end
          end else if (!hdr_long) begin
            case (hdr_dt)
              DtFs: begin
                frame_active_d = 1'b1;
                frame_start_d  = 1'b1;
                frame_num_d    = hdr_wc;
              end
              DtFe: begin
                frame_active_d = 1'b0;
                line_active_d  = 1'b0;
                frame_end_d    = 1'b1;
              end
              DtLs:    line_active_d = 1'b1;
              DtLe:    line_active_d = 1'b0;
              default: ;
            endcase
          end else if (wc_bad) begin
            err_wc_d = 1'b1;
            beats_d  = skip_beats;
            state_d  = StSkip;
          end else if (hdr_wc == 16'd0) begin
            state_d = StCrc;
          end else begin
            pix_dt_d = hdr_dt;
            beats_d  = {1'b0, hdr_wc[15:1]};
            state_d  = StPayload;
          end
        end
      end
      StPayload: begin
        if (data_valid_i) begin
          if (frame_active_q) begin
            pix_data_d  = data_in_i;
            pix_valid_d = 1'b1;
          end
          beats_d = beats_q - 16'd1;
          if (beats_q == 16'd1) state_d = StCrc;
        end
      end
      StCrc: begin
        if (data_valid_i) begin
          crc_word_d  = data_in_i;
          crc_valid_d = 1'b1;
          pkt_done_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      StSkip: begin
        if (data_valid_i) begin
          beats_d = beats_q - 16'd1;
          if (beats_q == 16'd1) state_d = StIdle;
        end
      end
      StResync: ;
      default:  state_d = StIdle;
    endcase

    // A CRC beat coincident with eot still completes the packet.
    if (eot_i) begin
      state_d       = StIdle;
      beats_d       = 16'd0;
      line_active_d = 1'b0;
      if (state_q == StPayload || (state_q == StCrc && !data_valid_i)) err_trunc_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      beats_q        <= 16'd0;
      pix_data_q     <= 16'd0;
      pix_valid_q    <= 1'b0;
      pix_dt_q       <= 6'd0;
      frame_active_q <= 1'b0;
      line_active_q  <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_num_q    <= 16'd0;
      crc_word_q     <= 16'd0;
      crc_valid_q    <= 1'b0;
      pkt_done_q     <= 1'b0;
      err_ecc_q      <= 1'b0;
      err_wc_q       <= 1'b0;
      err_trunc_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_q        <= beats_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      pix_dt_q       <= pix_dt_d;
      frame_active_q <= frame_active_d;
      line_active_q  <= line_active_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      frame_num_q    <= frame_num_d;
      crc_word_q     <= crc_word_d;
      crc_valid_q    <= crc_valid_d;
      pkt_done_q     <= pkt_done_d;
      err_ecc_q      <= err_ecc_d;
      err_wc_q       <= err_wc_d;
      err_trunc_q    <= err_trunc_d;
    end
  end

  assign pix_data_o     = pix_data_q;
  assign pix_valid_o    = pix_valid_q;
  assign pix_dt_o       = pix_dt_q;
  assign frame_active_o = frame_active_q;
  assign line_active_o  = line_active_q;
  assign frame_start_o  = frame_start_q;
  assign frame_end_o    = frame_end_q;
  assign frame_num_o    = frame_num_q;
  assign crc_word_o     = crc_word_q;
  assign crc_valid_o    = crc_valid_q;
  assign pkt_done_o     = pkt_done_q;
  assign err_ecc_o      = err_ecc_q;
  assign err_wc_o       = err_wc_q;
  assign err_trunc_o    = err_trunc_q;

endmodule

// File: tb/tb_csi_pkt_sequencer.sv
// Directed bench for csi_pkt_sequencer: hand-computed expectations, pulse counters per stimulus.
module tb_csi_pkt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] hdr_in;
  logic        hdr_valid, ecc_error;
  logic [15:0] data_in;
  logic        data_valid, eot;
  logic [15:0] pix_data, frame_num, crc_word;
  logic        pix_valid, frame_active, line_active, frame_start, frame_end;
  logic        crc_valid, pkt_done, err_ecc, err_wc, err_trunc;
  logic [5:0]  pix_dt;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_pix = 0, cnt_done = 0, cnt_ecc = 0, cnt_wc = 0, cnt_trunc = 0, cnt_fs = 0;

  always #5 clk = ~clk;

  csi_pkt_sequencer dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .hdr_in_i       (hdr_in),
    .hdr_valid_i    (hdr_valid),
    .ecc_error_i    (ecc_error),
    .data_in_i      (data_in),
    .data_valid_i   (data_valid),
    .eot_i          (eot),
    .pix_data_o     (pix_data),
    .pix_valid_o    (pix_valid),
    .pix_dt_o       (pix_dt),
    .frame_active_o (frame_active),
    .line_active_o  (line_active),
    .frame_start_o  (frame_start),
    .frame_end_o    (frame_end),
    .frame_num_o    (frame_num),
    .crc_word_o     (crc_word),
    .crc_valid_o    (crc_valid),
    .pkt_done_o     (pkt_done),
    .err_ecc_o      (err_ecc),
    .err_wc_o       (err_wc),
    .err_trunc_o    (err_trunc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: drive at negedge, sample #1 after posedge, accumulate output pulses.
  task automatic cyc(input logic rst, input logic [23:0] h, input logic hv, input logic ecc,
                     input logic [15:0] d, input logic dv, input logic e);
    @(negedge clk);
    reset = rst; hdr_in = h; hdr_valid = hv; ecc_error = ecc;
    data_in = d; data_valid = dv; eot = e;
    @(posedge clk);
    #1;
    cnt_pix   += int'(pix_valid);
    cnt_done  += int'(pkt_done);
    cnt_ecc   += int'(err_ecc);
    cnt_wc    += int'(err_wc);
    cnt_trunc += int'(err_trunc);
    cnt_fs    += int'(frame_start);
  endtask

  task automatic hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
    cyc(1'b0, {wc, vc, dt}, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [15:0] d);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic end_tx();
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int pix0, done0, trunc0, fs0;
    cyc(1'b1, 24'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    cyc(1'b1, 24'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    check("rst_frame_active", frame_active, 0);
    check("rst_line_active", line_active, 0);
    check("rst_frame_num", frame_num, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_crc_word", crc_word, 0);

    // Normal frame: FS, LS, long packet with 2 beats + CRC, LE, FE.
    hdr(6'h00, 2'd0, 16'd7);
    check("fs_start", frame_start, 1);
    check("fs_active", frame_active, 1);
    check("fs_num", frame_num, 7);
    hdr(6'h02, 2'd0, 16'd0);
    check("ls_active", line_active, 1);
    check("fs_pulse_1cyc", frame_start, 0);
    hdr(6'h2A, 2'd0, 16'd4);
    check("long_dt", pix_dt, 6'h2A);
    beat(16'h1234);
    check("beat0_valid", pix_valid, 1);
    check("beat0_data", pix_data, 16'h1234);
    beat(16'h5678);
    check("beat1_data", pix_data, 16'h5678);
    beat(16'hBEEF);
    check("crc_valid", crc_valid, 1);
    check("crc_word", crc_word, 16'hBEEF);
    check("crc_pkt_done", pkt_done, 1);
    check("crc_no_pix", pix_valid, 0);
    hdr(6'h03, 2'd0, 16'd0);
    check("le_line", line_active, 0);
    hdr(6'h01, 2'd0, 16'd0);
    check("fe_end", frame_end, 1);
    check("fe_active", frame_active, 0);
    check("t1_pix_count", cnt_pix, 2);

    // ECC-rejected header, data and eot ignored until resync.
    pix0 = cnt_pix;
    cyc(1'b0, {16'd3, 2'd0, 6'h00}, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
    check("ecc_no_fs", frame_active, 0);
    for (int i = 0; i < 5; i++) beat(16'h0F00 + 16'(i));
    end_tx();
    check("ecc_count", cnt_ecc, 1);
    check("ecc_no_pix", cnt_pix, pix0);
    hdr(6'h00, 2'd0, 16'd11);
    check("ecc_fs_after", frame_start, 1);
    check("ecc_fs_num", frame_num, 11);

    // Odd word count: error, then (5+3)>>1 = 4 beats skipped.
    hdr(6'h2B, 2'd0, 16'd5);
    check("wc_odd_err", err_wc, 1);
    for (int i = 0; i < 4; i++) beat(16'hA000 + 16'(i));
    check("wc_skip_no_pix", cnt_pix, pix0);
    hdr(6'h00, 2'd0, 16'd9);
    check("wc_fs_after", frame_num, 9);
    check("wc_count", cnt_wc, 1);

    // Truncated packet: eot after 2 of 4 beats.
    hdr(6'h02, 2'd0, 16'd0);
    hdr(6'h2A, 2'd0, 16'd8);
    beat(16'h0001);
    beat(16'h0002);
    done0 = cnt_done;
    end_tx();
    check("trunc_err", err_trunc, 1);
    check("trunc_line", line_active, 0);
    check("trunc_frame", frame_active, 1);
    check("trunc_pix", cnt_pix, pix0 + 2);
    check("trunc_no_done", cnt_done, done0);

    // VC mismatch: short ignored, long skipped (2 beats), back in IDLE.
    hdr(6'h01, 2'd0, 16'd0);
    fs0 = cnt_fs;
    hdr(6'h00, 2'd1, 16'd5);
    check("vc_fs_ignored", frame_active, 0);
    hdr(6'h2A, 2'd1, 16'd2);
    beat(16'h1111);
    beat(16'h2222);
    hdr(6'h02, 2'd0, 16'd0);
    check("vc_skip_len", line_active, 1);
    check("vc_no_fs", cnt_fs, fs0);
    check("vc_no_pix", cnt_pix, pix0 + 2);
    hdr(6'h03, 2'd0, 16'd0);

    // Long packet while frame inactive: counted, not emitted, still completes.
    hdr(6'h2A, 2'd0, 16'd2);
    beat(16'hAAAA);
    check("nofr_no_pix", pix_valid, 0);
    beat(16'h1357);
    check("nofr_done", pkt_done, 1);
    check("nofr_crc", crc_word, 16'h1357);

    // eot coincident with CRC beat completes normally.
    trunc0 = cnt_trunc;
    hdr(6'h2A, 2'd0, 16'd2);
    beat(16'h0BAD);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 16'h2468, 1'b1, 1'b1);
    check("eotcrc_done", pkt_done, 1);
    check("eotcrc_crc", crc_word, 16'h2468);
    check("eotcrc_no_trunc", cnt_trunc, trunc0);

    // Zero word count: straight to CRC.
    hdr(6'h2C, 2'd0, 16'd0);
    beat(16'h0C0C);
    check("wc0_done", pkt_done, 1);
    check("wc0_crc", crc_word, 16'h0C0C);

    // Word count above MAX_WC; eot while skipping is silent.
    hdr(6'h2A, 2'd0, 16'd4098);
    check("wc_big_err", err_wc, 1);
    end_tx();
    check("skip_eot_no_trunc", cnt_trunc, trunc0);
    hdr(6'h00, 2'd0, 16'd21);
    check("big_fs_after", frame_num, 21);

    // Reset mid-packet: no error pulses, outputs cleared.
    hdr(6'h2A, 2'd0, 16'd6);
    beat(16'h7777);
    trunc0 = cnt_trunc;
    cyc(1'b1, 24'd0, 1'b0, 1'b0, 16'h8888, 1'b1, 1'b0);
    check("rst_mid_pix", pix_valid, 0);
    check("rst_mid_frame", frame_active, 0);
    check("rst_mid_no_trunc", cnt_trunc, trunc0);
    hdr(6'h00, 2'd0, 16'd2);
    check("rst_mid_fs", frame_start, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
